// File: rtl/run_len_enc.sv
// Run-length encoder: folds consecutive equal samples into (value, length, last) tokens.
// A single registered token slot drives the output; in_last closes the line.
module run_len_enc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_last,
  input  logic              out_ready
);

  localparam logic [LEN_W-1:0] MaxLen = '1;
  localparam logic [LEN_W-1:0] OneLen = LEN_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] run_val_q, run_val_d;
  logic [LEN_W-1:0]  run_len_q, run_len_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [LEN_W-1:0]  out_len_q, out_len_d;
  logic              out_last_q, out_last_d;

  logic slot_free;
  logic accept;
  logic extend;

  // The slot counts as free when it is empty or its token leaves on this edge.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = rst_n && (state_q != StFlush) && slot_free;
  assign accept    = in_valid && in_ready;
  assign extend    = (in_data == run_val_q) && (run_len_q != MaxLen);

  always_comb begin
    state_d     = state_q;
    run_val_d   = run_val_q;
    run_len_d   = run_len_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    out_last_d  = out_last_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_len_d   = OneLen;
            out_last_d  = 1'b1;
          end else begin
            run_val_d = in_data;
            run_len_d = OneLen;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (extend) begin
            if (in_last) begin
              out_valid_d = 1'b1;
              out_data_d  = run_val_q;
              out_len_d   = run_len_q + OneLen;
              out_last_d  = 1'b1;
              run_len_d   = '0;
              state_d     = StIdle;
            end else begin
              run_len_d = run_len_q + OneLen;
            end
          end else begin
            // Value change or saturation: close the old run, start a new one.
            out_valid_d = 1'b1;
            out_data_d  = run_val_q;
            out_len_d   = run_len_q;
            out_last_d  = 1'b0;
            run_val_d   = in_data;
            run_len_d   = OneLen;
            if (in_last) begin
              state_d = StFlush;
            end
          end
        end
      end
      StFlush: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = run_val_q;
          out_len_d   = OneLen;
          out_last_d  = 1'b1;
          run_len_d   = '0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      run_val_q   <= '0;
      run_len_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_val_q   <= run_val_d;
      run_len_q   <= run_len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_run_len_enc.sv
// Bench for run_len_enc (LEN_W=3 so saturation is frequent): directed vector table,
// reset corner sequences, then random traffic scored against a run-grouping model.
module tb_run_len_enc;

  localparam int DW     = 16;
  localparam int LW     = 3;
  localparam int MAXLEN = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_len;
  logic          out_last;
  logic          out_ready = 1'b0;

  run_len_enc #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: group accepted samples into runs of equal value, cap at MAXLEN,
  // and mark the run closed by in_last.
  typedef struct {
    logic [DW-1:0] d;
    int            len;
    logic          last;
  } tok_t;

  tok_t          exp_q[$];
  logic [DW-1:0] m_val = '0;
  int            m_cnt = 0;
  bit            mon_en = 1'b0;

  task automatic model_push(input logic [DW-1:0] v, input logic l);
    tok_t t;
    if (m_cnt != 0 && (v != m_val || m_cnt == MAXLEN)) begin
      t.d = m_val; t.len = m_cnt; t.last = 1'b0;
      exp_q.push_back(t);
      m_cnt = 0;
    end
    if (m_cnt == 0) m_val = v;
    m_cnt++;
    if (l) begin
      t.d = m_val; t.len = m_cnt; t.last = 1'b1;
      exp_q.push_back(t);
      m_cnt = 0;
    end
  endtask

  // Scoreboard and hold-stability monitor.
  initial begin : monitor
    bit            hold_prev = 1'b0;
    logic [DW-1:0] p_data;
    logic [LW-1:0] p_len;
    logic          p_last;
    tok_t          t;
    forever begin
      @(posedge clk);
      if (mon_en && rst_n) begin
        if (hold_prev) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_fields", {out_data, 12'(out_len), 4'(out_last)},
              {p_data, 12'(p_len), 4'(p_last)});
        end
        if (in_valid && in_ready) model_push(in_data, in_last);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_token", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            t = exp_q.pop_front();
            chk("tok_data", 32'(out_data), 32'(t.d));
            chk("tok_len", 32'(out_len), 32'(t.len));
            chk("tok_last", 32'(out_last), 32'(t.last));
          end
        end
        hold_prev = out_valid && !out_ready;
        p_data = out_data; p_len = out_len; p_last = out_last;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    bit            l;
    bit            ordy;
    bit            e_ir;
    bit            e_ov;
    logic [DW-1:0] e_d;
    int            e_len;
    bit            e_last;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input int d, input bit l, input bit ordy, input bit e_ir,
                     input bit e_ov, input int e_d, input int e_len, input bit e_last);
    vec_t x;
    x.v = v; x.d = DW'(d); x.l = l; x.ordy = ordy; x.e_ir = e_ir;
    x.e_ov = e_ov; x.e_d = DW'(e_d); x.e_len = e_len; x.e_last = e_last;
    tbl.push_back(x);
  endtask

  initial begin
    bit ok;
    // 5,5,5,7(last): (5,3,0) then one FLUSH bubble and (7,1,1)
    add(1, 5, 0, 1, 1, 0, 0, 0, 0);
    add(1, 5, 0, 1, 1, 0, 0, 0, 0);
    add(1, 5, 0, 1, 1, 0, 0, 0, 0);
    add(1, 7, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 5, 3, 0);
    add(0, 0, 0, 1, 1, 1, 7, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // 9,9,9,9(last): single (9,4,1), in_ready stays high
    for (int i = 0; i < 3; i++) add(1, 9, 0, 1, 1, 0, 0, 0, 0);
    add(1, 9, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 9, 4, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // lone 3 with last from IDLE
    add(1, 3, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 3, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // ten 2s with LEN_W=3: saturation split (2,7,0), (2,3,1)
    for (int i = 0; i < 8; i++) add(1, 2, 0, 1, 1, 0, 0, 0, 0);
    add(1, 2, 0, 1, 1, 1, 2, 7, 0);
    add(1, 2, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 2, 3, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // 1,2,3,4(last) with out_ready low for 5 cycles: (1,1,0) held, back-pressure
    add(1, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 2, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 3, 0, 0, 0, 1, 1, 1, 0);
    add(1, 3, 0, 1, 1, 1, 1, 1, 0);
    add(1, 4, 1, 1, 1, 1, 2, 1, 0);
    add(0, 0, 0, 1, 0, 1, 3, 1, 0);
    add(0, 0, 0, 1, 1, 1, 4, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fields", {out_data, 12'(out_len), 4'(out_last)}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_d));
        chk($sformatf("v%0d_out_len", i), 32'(out_len), 32'(tbl[i].e_len));
        chk($sformatf("v%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_last));
      end
    end

    // 4,4,4 then reset: the open run is discarded, only (6,1,1) comes out
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'd4; in_last = 1'b0; out_ready = 1'b1;
      #1 chk("r4_in_ready", 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1 chk("r4_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_data = 16'd6; in_last = 1'b1;
    #1;
    chk("r6_in_ready", 32'(in_ready), 32'd1);
    chk("r6_no_stale", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("r6_out_valid", 32'(out_valid), 32'd1);
    chk("r6_out_tok", {out_data, 12'(out_len), 4'(out_last)}, {16'd6, 12'd1, 4'd1});
    @(negedge clk);
    #1 chk("r6_drained", 32'(out_valid), 32'd0);

    // Reset while in FLUSH with a pending token: both are dropped
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd1; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_data = 16'd2; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("fl_out_valid", 32'(out_valid), 32'd1);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("fl_rst_valid", 32'(out_valid), 32'd0);
    chk("fl_rst_fields", {out_data, 12'(out_len), 4'(out_last)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("fl_rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1 chk("fl_no_flush_tok", 32'(out_valid), 32'd0);

    // Random traffic against the model
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        in_valid = 1'b0; rst_n = 1'b0;
        exp_q.delete(); m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom_range(0, 2));
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Close the line and drain everything
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = '0; in_last = 1'b1; out_ready = 1'b1;
      #1 ok = in_ready;
      @(posedge clk);
    end
    chk("final_accept", 32'(ok), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 50 && (exp_q.size() != 0 || out_valid); k++) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_idle", 32'(out_valid), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
